// File: rtl/dr_pkg.sv
// dr_pkg: shared state type, constants and helpers for dance_round_ctrl.
// The LFSR step function only exists when LFSR_PATTERN_EN is defined.
package dr_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_COUNTDOWN,
        ST_PLAY,
        ST_DONE
    } state_e;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    // Galois mask for x^16 + x^14 + x^13 + x^11 + 1
    localparam logic [15:0] LFSR_TAPS = 16'hB400;
    localparam logic [1:0]  CD_LEN    = 2'd3;

    function automatic logic [3:0] onehot2(input logic [1:0] idx);
        return 4'b0001 << idx;
    endfunction

    function automatic logic [15:0] sat_inc(input logic [15:0] v,
                                            input logic en);
        return (en && (v != 16'hFFFF)) ? v + 16'd1 : v;
    endfunction

`ifdef LFSR_PATTERN_EN
    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
    endfunction
`endif

endpackage

// File: rtl/dr_step_timer.sv
// dr_step_timer: reloadable down-counter; tick_o marks the last cycle
// of each step period while run_i is high.
module dr_step_timer #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic         run_i,
    input  logic [W-1:0] period_i,
    output logic         tick_o
);

    logic [W-1:0] cnt_q, cnt_d;

    assign tick_o = run_i && (cnt_q == '0);

    always_comb begin
        cnt_d = cnt_q;
        if (load_i || tick_o) begin
            cnt_d = period_i - W'(1);
        end else if (run_i) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/dance_round_ctrl.sv
// dance_round_ctrl: two-player step-judging round controller.
// Define LFSR_PATTERN_EN for LFSR-driven targets instead of rotation.
module dance_round_ctrl
    import dr_pkg::*;
#(
    parameter int STEP_DIV  = 8000,
    parameter int NUM_STEPS = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [1:0]  speed_sel,
    input  logic [7:0]  btn_ctr,
    output logic [3:0]  arrow1,
    output logic [3:0]  arrow2,
    output logic        clk_gamespeed,
    output logic [3:0]  gameinter,
    output logic [15:0] errorpress_1,
    output logic [15:0] errorpress_2,
    output logic        game_over,
    output logic [1:0]  winner
);

    localparam int         TW   = $clog2(STEP_DIV + 1);
    localparam logic [7:0] LAST = 8'(NUM_STEPS - 1);

    state_e      state_q, state_d;
    logic [1:0]  speed_q, speed_d;
    logic [1:0]  cd_q, cd_d;
    logic [7:0]  step_q, step_d;
    logic [3:0]  arrow_q, arrow_d;
    logic [7:0]  btn_q;
    logic [1:0]  judged_q, judged_d;
    logic [15:0] err1_q, err1_d;
    logic [15:0] err2_q, err2_d;
`ifdef LFSR_PATTERN_EN
    logic [15:0] lfsr_q, lfsr_d, lfsr_n;
`endif

    logic          tick, run, start_ok, clr, inc1, inc2;
    logic [TW-1:0] period;
    logic [7:0]    edges;
    logic [3:0]    gi;

    assign edges    = btn_ctr & ~btn_q;
    assign start_ok = start && (state_q == ST_IDLE || state_q == ST_DONE);
    assign run      = (state_q == ST_COUNTDOWN) || (state_q == ST_PLAY);
    // The reload on start must see the speed being latched, not the old one.
    assign period   = TW'(STEP_DIV >> (start_ok ? speed_sel : speed_q));

    dr_step_timer #(.W(TW)) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_i  (start_ok),
        .run_i   (run),
        .period_i(period),
        .tick_o  (tick)
    );

    always_comb begin
        state_d  = state_q;
        speed_d  = speed_q;
        cd_d     = cd_q;
        step_d   = step_q;
        arrow_d  = arrow_q;
        judged_d = judged_q;
        clr      = 1'b0;
        inc1     = 1'b0;
        inc2     = 1'b0;
`ifdef LFSR_PATTERN_EN
        lfsr_d   = lfsr_q;
        lfsr_n   = lfsr_next(lfsr_q);
`endif
        if (state_q == ST_PLAY) begin
            if (!judged_q[1] && (edges[7:4] != 4'd0)) begin
                judged_d[1] = 1'b1;
                inc1        = (edges[7:4] != arrow_q);
            end
            if (!judged_q[0] && (edges[3:0] != 4'd0)) begin
                judged_d[0] = 1'b1;
                inc2        = (edges[3:0] != arrow_q);
            end
            // A press landing on the boundary still belongs to this step.
            if (tick) begin
                inc1     = inc1 | !judged_d[1];
                inc2     = inc2 | !judged_d[0];
                judged_d = 2'b00;
            end
        end
        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d = ST_COUNTDOWN;
                    speed_d = speed_sel;
                    cd_d    = CD_LEN;
                    clr     = 1'b1;
                end
            end
            ST_COUNTDOWN: begin
                if (tick) begin
                    if (cd_q == 2'd1) begin
                        state_d  = ST_PLAY;
                        step_d   = 8'd0;
                        judged_d = 2'b00;
`ifdef LFSR_PATTERN_EN
                        arrow_d  = onehot2(lfsr_q[1:0]);
`else
                        arrow_d  = onehot2(2'd0);
`endif
                    end else begin
                        cd_d = cd_q - 2'd1;
                    end
                end
            end
            ST_PLAY: begin
                if (tick) begin
`ifdef LFSR_PATTERN_EN
                    lfsr_d = lfsr_n;
`endif
                    if (step_q == LAST) begin
                        state_d = ST_DONE;
                        arrow_d = 4'd0;
                    end else begin
                        step_d  = step_q + 8'd1;
`ifdef LFSR_PATTERN_EN
                        arrow_d = onehot2(lfsr_n[1:0]);
`else
                        arrow_d = {arrow_q[2:0], arrow_q[3]};
`endif
                    end
                end
            end
            default: ;
        endcase
        err1_d = clr ? 16'd0 : sat_inc(err1_q, inc1);
        err2_d = clr ? 16'd0 : sat_inc(err2_q, inc2);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            speed_q  <= 2'd0;
            cd_q     <= 2'd0;
            step_q   <= 8'd0;
            arrow_q  <= 4'd0;
            btn_q    <= 8'd0;
            judged_q <= 2'b00;
            err1_q   <= 16'd0;
            err2_q   <= 16'd0;
`ifdef LFSR_PATTERN_EN
            lfsr_q   <= LFSR_SEED;
`endif
        end else begin
            state_q  <= state_d;
            speed_q  <= speed_d;
            cd_q     <= cd_d;
            step_q   <= step_d;
            arrow_q  <= arrow_d;
            btn_q    <= btn_ctr;
            judged_q <= judged_d;
            err1_q   <= err1_d;
            err2_q   <= err2_d;
`ifdef LFSR_PATTERN_EN
            lfsr_q   <= lfsr_d;
`endif
        end
    end

    always_comb begin
        gi = 4'd0;
        if (state_q == ST_COUNTDOWN) begin
            gi = {2'b00, cd_q};
        end else if (state_q == ST_PLAY) begin
            gi = step_q[3:0];
        end
    end

    always_comb begin
        winner = 2'b00;
        if (state_q == ST_DONE) begin
            if (err1_q < err2_q) begin
                winner = 2'b01;
            end else if (err2_q < err1_q) begin
                winner = 2'b10;
            end else begin
                winner = 2'b11;
            end
        end
    end

    assign arrow1        = arrow_q;
    assign arrow2        = arrow_q;
    assign clk_gamespeed = tick;
    assign gameinter     = gi;
    assign errorpress_1  = err1_q;
    assign errorpress_2  = err2_q;
    assign game_over     = (state_q == ST_DONE);

endmodule

// File: tb/tb_dance_round_ctrl.sv
// tb_dance_round_ctrl: directed rounds checked every cycle against a
// timeline model of the round (STEP_DIV=8, NUM_STEPS=4).
module tb_dance_round_ctrl;

    localparam int SD = 8;
    localparam int NS = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  speed_sel = 2'd0;
    logic [7:0]  btn_ctr = 8'd0;
    logic [3:0]  arrow1, arrow2, gameinter;
    logic        clk_gamespeed, game_over;
    logic [15:0] errorpress_1, errorpress_2;
    logic [1:0]  winner;

    dance_round_ctrl #(.STEP_DIV(SD), .NUM_STEPS(NS)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .speed_sel    (speed_sel),
        .btn_ctr      (btn_ctr),
        .arrow1       (arrow1),
        .arrow2       (arrow2),
        .clk_gamespeed(clk_gamespeed),
        .gameinter    (gameinter),
        .errorpress_1 (errorpress_1),
        .errorpress_2 (errorpress_2),
        .game_over    (game_over),
        .winner       (winner)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    endtask

    // Model: the round is a timeline of m_t cycles since start was taken.
    bit          m_run = 1'b0;
    int          m_t = 0;
    int          m_P = SD;
    logic [15:0] m_err1 = 16'd0;
    logic [15:0] m_err2 = 16'd0;
    logic [7:0]  m_prev = 8'd0;
    bit          m_j1 = 1'b0;
    bit          m_j2 = 1'b0;
    logic [15:0] m_lfsr = 16'hACE1;

    function automatic logic [3:0] m_target();
        logic [3:0] one;
        int s;
        one = 4'b0001;
        s = (m_t - 3 * m_P) / m_P;
`ifdef LFSR_PATTERN_EN
        s = int'(m_lfsr[1:0]);
`endif
        if (s < 0) s = 0;
        return one << (s % 4);
    endfunction

    function automatic logic [15:0] m_sat(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always @(negedge clk) begin
        int cd_end, end_t;
        bit in_rnd, in_play, done, e_pulse;
        logic [3:0] e_arrow, e_gi, tgt;
        logic [1:0] e_win;
        logic [7:0] ed;
        cd_end  = 3 * m_P;
        end_t   = (3 + NS) * m_P;
        in_rnd  = m_run && (m_t < end_t);
        in_play = in_rnd && (m_t >= cd_end);
        done    = m_run && !in_rnd;
        tgt     = m_target();
        e_pulse = in_rnd && ((m_t % m_P) == m_P - 1);
        if (!in_rnd) e_gi = 4'd0;
        else if (!in_play) e_gi = 4'(3 - m_t / m_P);
        else e_gi = 4'(((m_t - cd_end) / m_P) % 16);
        e_arrow = in_play ? tgt : 4'd0;
        if (!done) e_win = 2'b00;
        else if (m_err1 < m_err2) e_win = 2'b01;
        else if (m_err2 < m_err1) e_win = 2'b10;
        else e_win = 2'b11;

        check("arrow1", 32'(arrow1), 32'(e_arrow));
        check("arrow2", 32'(arrow2), 32'(e_arrow));
        check("pulse", 32'(clk_gamespeed), 32'(e_pulse));
        check("gameinter", 32'(gameinter), 32'(e_gi));
        check("err1", 32'(errorpress_1), 32'(m_err1));
        check("err2", 32'(errorpress_2), 32'(m_err2));
        check("game_over", 32'(game_over), 32'(done));
        check("winner", 32'(winner), 32'(e_win));

        if (!rst_n) begin
            m_run = 1'b0; m_t = 0; m_err1 = 16'd0; m_err2 = 16'd0;
            m_prev = 8'd0; m_j1 = 1'b0; m_j2 = 1'b0; m_lfsr = 16'hACE1;
        end else begin
            ed = btn_ctr & ~m_prev;
            m_prev = btn_ctr;
            if (in_play) begin
                if (!m_j1 && ed[7:4] != 4'd0) begin
                    m_j1 = 1'b1;
                    if (ed[7:4] != tgt) m_err1 = m_sat(m_err1);
                end
                if (!m_j2 && ed[3:0] != 4'd0) begin
                    m_j2 = 1'b1;
                    if (ed[3:0] != tgt) m_err2 = m_sat(m_err2);
                end
                if (e_pulse) begin
                    if (!m_j1) m_err1 = m_sat(m_err1);
                    if (!m_j2) m_err2 = m_sat(m_err2);
                    m_j1 = 1'b0; m_j2 = 1'b0;
                    m_lfsr = m_lfsr[0] ? ((m_lfsr >> 1) ^ 16'hB400) : (m_lfsr >> 1);
                end
            end
            if (!in_rnd && start) begin
                m_run = 1'b1; m_t = 0; m_P = SD >> speed_sel;
                m_err1 = 16'd0; m_err2 = 16'd0; m_j1 = 1'b0; m_j2 = 1'b0;
            end else if (in_rnd) begin
                m_t++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [3:0] p1, p2;
        repeat (3) tick();
        rst_n = 1'b1;
        check("rst_arrow", 32'(arrow1), 32'd0);
        check("rst_gi", 32'(gameinter), 32'd0);
        check("rst_over", 32'(game_over), 32'd0);

        // Round A: player 1 hits every target, player 2 idle.
        speed_sel = 2'd0; start = 1'b1; tick(); start = 1'b0;
        for (int t = 0; t < 58; t++) begin
            p1 = (t >= 24 && (t - 24) % 8 == 2) ? m_target() : 4'd0;
            btn_ctr = {p1, 4'd0};
            if (t == 5) speed_sel = 2'd3;
            if (t == 0) check("A_gi3", 32'(gameinter), 32'd3);
            if (t == 7) check("A_pulse7", 32'(clk_gamespeed), 32'd1);
            if (t == 8) check("A_gi2", 32'(gameinter), 32'd2);
            if (t == 16) check("A_gi1", 32'(gameinter), 32'd1);
`ifndef LFSR_PATTERN_EN
            if (t == 24) check("A_arrow0", 32'(arrow1), 32'h1);
            if (t == 32) check("A_arrow1", 32'(arrow1), 32'h2);
`endif
            tick();
        end
        check("A_over", 32'(game_over), 32'd1);
        check("A_err1", 32'(errorpress_1), 32'd0);
        check("A_err2", 32'(errorpress_2), 32'd4);
        check("A_winner", 32'(winner), 32'h1);
        check("A_model_err2", 32'(m_err2), 32'd4);

        // Round B from DONE: wrong chord then target; P2 hits, last on boundary.
        speed_sel = 2'd0; start = 1'b1; tick(); start = 1'b0;
        check("B_clr1", 32'(errorpress_1), 32'd0);
        check("B_clr2", 32'(errorpress_2), 32'd0);
        for (int t = 0; t < 58; t++) begin
            p1 = 4'd0;
            if (t == 26 || t == 27) p1 = 4'b0011;
            if (t == 29) p1 = m_target();
            if (t >= 32 && (t - 24) % 8 == 2) p1 = m_target();
            p2 = 4'd0;
            if ((t >= 24 && t < 48 && (t - 24) % 8 == 2) || t == 55) p2 = m_target();
            btn_ctr = {p1, p2};
            if (t == 30) check("B_err1_step0", 32'(errorpress_1), 32'd1);
            if (t == 32) check("B_err1_after", 32'(errorpress_1), 32'd1);
            tick();
        end
        check("B_err1", 32'(errorpress_1), 32'd1);
        check("B_err2", 32'(errorpress_2), 32'd0);
        check("B_winner", 32'(winner), 32'h2);
        check("B_model_err1", 32'(m_err1), 32'd1);

        // Round C: speed 2, held button across PLAY entry, reset mid-PLAY.
        btn_ctr = 8'd0; speed_sel = 2'd2; start = 1'b1; tick(); start = 1'b0;
        for (int t = 0; t < 9; t++) begin
            btn_ctr = (t >= 2) ? 8'h10 : 8'h00;
            start = (t == 3 || t == 7);
            if (t == 0) check("C_gi3", 32'(gameinter), 32'd3);
            if (t == 1) check("C_pulse1", 32'(clk_gamespeed), 32'd1);
            if (t == 2) check("C_nopulse2", 32'(clk_gamespeed), 32'd0);
            if (t == 3) check("C_pulse3", 32'(clk_gamespeed), 32'd1);
            if (t == 4) check("C_gi1", 32'(gameinter), 32'd1);
`ifndef LFSR_PATTERN_EN
            if (t == 6) check("C_arrow", 32'(arrow1), 32'h1);
`endif
            if (t == 8) check("C_err1", 32'(errorpress_1), 32'd1);
            if (t == 8) check("C_err2", 32'(errorpress_2), 32'd1);
            tick();
        end
        start = 1'b0; rst_n = 1'b0; tick();
        check("R_arrow1", 32'(arrow1), 32'd0);
        check("R_arrow2", 32'(arrow2), 32'd0);
        check("R_pulse", 32'(clk_gamespeed), 32'd0);
        check("R_gi", 32'(gameinter), 32'd0);
        check("R_err1", 32'(errorpress_1), 32'd0);
        check("R_err2", 32'(errorpress_2), 32'd0);
        check("R_over", 32'(game_over), 32'd0);
        check("R_winner", 32'(winner), 32'd0);
        rst_n = 1'b1; btn_ctr = 8'd0;
        repeat (3) tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
